// File: rtl/env_scan_reader_pkg.sv
// Shared types and constants for the environment-grid scan reader.
// Holds coordinate/signal widths, grid extents, the scan FSM state type,
// the streamed cell tuple and the saturating accumulator helpers.
package env_scan_reader_pkg;

  localparam int X_BITS      = 8;
  localparam int Y_BITS      = 7;
  localparam int SIGNAL_BITS = 4;
  localparam int CELL_BITS   = X_BITS + Y_BITS + 1 + SIGNAL_BITS;

  // Last column / row scanned (640/4 - 1, 480/4 - 1)
  localparam logic [X_BITS-1:0] X_MAX = 8'd159;
  localparam logic [Y_BITS-1:0] Y_MAX = 7'd119;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scan_state_t;

  typedef struct packed {
    logic [X_BITS-1:0]      x;
    logic [Y_BITS-1:0]      y;
    logic                   sugar;
    logic [SIGNAL_BITS-1:0] signal;
  } cell_t;

  // Add a single bit to a 16-bit counter, sticking at all-ones
  function automatic logic [15:0] sat_inc16(input logic [15:0] acc, input logic inc);
    logic [16:0] sum;
    sum = {1'b0, acc} + {16'd0, inc};
    if (sum[16]) begin
      return 16'hFFFF;
    end else begin
      return sum[15:0];
    end
  endfunction

  // Add a signal value to a 24-bit sum, sticking at all-ones
  function automatic logic [23:0] sat_add24(input logic [23:0] acc, input logic [SIGNAL_BITS-1:0] val);
    logic [24:0] sum;
    sum = {1'b0, acc} + {21'd0, val};
    if (sum[24]) begin
      return 24'hFFFFFF;
    end else begin
      return sum[23:0];
    end
  endfunction

endpackage

// File: rtl/env_scan_reader_cell_skid_buf.sv
// Two-entry valid/ready buffer of cell tuples. The head entry drives the
// consumer directly from a register. The producer only pushes when it has
// reserved room, so no overflow check is needed here.
module cell_skid_buf
  import env_scan_reader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [CELL_BITS-1:0] push_cell,
  input  logic                 pop,
  output logic [CELL_BITS-1:0] head,
  output logic [1:0]           occ
);

  logic [CELL_BITS-1:0] tail;

  // Storage update: head is always the oldest entry, tail the younger one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= {CELL_BITS{1'b0}};
      tail <= {CELL_BITS{1'b0}};
      occ  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            head <= push_cell;
          end else begin
            tail <= push_cell;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd2) begin
            head <= tail;
            tail <= push_cell;
          end else begin
            head <= push_cell;
          end
        end
        default: begin
          occ <= occ;
        end
      endcase
    end
  end

endmodule

// File: rtl/env_scan_reader.sv
// Read-side master for the environment grid: walks every cell in row-major
// order through the lookup port and streams (x, y, sugar, signal) tuples
// over valid/ready. Lookup data returns one cycle after the address.
// Optional build macro: ENV_SCAN_STATS_EN adds per-scan sugar count and
// signal sum accumulators; without it both outputs are tied to zero.
module env_scan_reader
  import env_scan_reader_pkg::*;
(
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [X_BITS-1:0]      lookup_X,
  output logic [Y_BITS-1:0]      lookup_Y,
  input  logic                   lookup_sugar,
  input  logic [SIGNAL_BITS-1:0] lookup_signal,
  output logic                   cell_valid,
  input  logic                   cell_ready,
  output logic [X_BITS-1:0]      cell_x,
  output logic [Y_BITS-1:0]      cell_y,
  output logic                   cell_sugar,
  output logic [SIGNAL_BITS-1:0] cell_signal,
  output logic                   cell_last,
  output logic [15:0]            sugar_count,
  output logic [23:0]            signal_sum
);

  scan_state_t         state;
  logic [X_BITS-1:0]   next_x, last_x;
  logic [Y_BITS-1:0]   next_y, last_y;
  logic                rd_pend;
  logic                issue, xfer, at_end, start_scan;
  logic [1:0]          occ;
  cell_t               head, capt;

  assign start_scan = (state == IDLE) && start;
  assign xfer       = cell_valid && cell_ready;
  assign at_end     = (next_x == X_MAX) && (next_y == Y_MAX);
  // Read issued last cycle has its data on the lookup bus now
  assign capt       = {last_x, last_y, lookup_sugar, lookup_signal};

  // Issue a read only while room remains for it once it lands; a tuple leaving this cycle frees a slot
  always_comb begin
    issue = 1'b0;
    if (state == SCAN) begin
      if (({1'b0, occ} + {2'b00, rd_pend} - {2'b00, xfer}) < 3'd2) begin
        issue = 1'b1;
      end else begin
        issue = 1'b0;
      end
    end else begin
      issue = 1'b0;
    end
  end

  // Lookup shows the address being issued, otherwise holds the last issued one
  always_comb begin
    lookup_X = last_x;
    lookup_Y = last_y;
    if (issue) begin
      lookup_X = next_x;
      lookup_Y = next_y;
    end else begin
      lookup_X = last_x;
      lookup_Y = last_y;
    end
  end

  // Row-major address counters and the one-deep read-in-flight marker
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      next_x  <= {X_BITS{1'b0}};
      next_y  <= {Y_BITS{1'b0}};
      last_x  <= {X_BITS{1'b0}};
      last_y  <= {Y_BITS{1'b0}};
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= issue;
      if (start_scan) begin
        next_x <= {X_BITS{1'b0}};
        next_y <= {Y_BITS{1'b0}};
      end else if (issue) begin
        last_x <= next_x;
        last_y <= next_y;
        if (next_x == X_MAX) begin
          next_x <= {X_BITS{1'b0}};
          next_y <= (next_y == Y_MAX) ? {Y_BITS{1'b0}} : next_y + 7'd1;
        end else begin
          next_x <= next_x + 8'd1;
        end
      end else begin
        next_x <= next_x;
      end
    end
  end

  // Scan sequencing with registered busy/done; start only honoured in IDLE
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= SCAN;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end
        SCAN: begin
          busy <= 1'b1;
          done <= 1'b0;
          if (issue && at_end) begin
            state <= DRAIN;
          end else begin
            state <= SCAN;
          end
        end
        DRAIN: begin
          if ((occ == 2'd0) && !rd_pend) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  cell_skid_buf u_buf (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .push      (rd_pend),
    .push_cell (capt),
    .pop       (xfer),
    .head      (head),
    .occ       (occ)
  );

  assign cell_valid  = (occ != 2'd0);
  assign cell_x      = head.x;
  assign cell_y      = head.y;
  assign cell_sugar  = head.sugar;
  assign cell_signal = head.signal;
  assign cell_last   = cell_valid && (head.x == X_MAX) && (head.y == Y_MAX);

`ifdef ENV_SCAN_STATS_EN
  // Per-scan statistics: cleared on start, accumulate every accepted tuple, hold after done
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sugar_count <= 16'd0;
      signal_sum  <= 24'd0;
    end else if (start_scan) begin
      sugar_count <= 16'd0;
      signal_sum  <= 24'd0;
    end else if (xfer) begin
      sugar_count <= sat_inc16(sugar_count, head.sugar);
      signal_sum  <= sat_add24(signal_sum, head.signal);
    end else begin
      sugar_count <= sugar_count;
      signal_sum  <= signal_sum;
    end
  end
`else
  assign sugar_count = 16'd0;
  assign signal_sum  = 24'd0;
`endif

endmodule

// File: tb/tb_env_scan_reader.sv
// Self-checking bench for env_scan_reader: a grid environment model with
// one-cycle read latency, an expected row-major tuple queue built from the
// grid contents, and randomized grid data / consumer backpressure.
module tb_env_scan_reader;
  import env_scan_reader_pkg::*;

  localparam int BUDGET = 45000;
  localparam int NCELLS = 160 * 120;
`ifdef ENV_SCAN_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        start = 1'b0;
  logic        cell_ready = 1'b0;
  logic        busy, done, cell_valid, cell_sugar, cell_last;
  logic [7:0]  lookup_X, cell_x;
  logic [6:0]  lookup_Y, cell_y;
  logic        lookup_sugar;
  logic [3:0]  lookup_signal, cell_signal;
  logic [15:0] sugar_count;
  logic [23:0] signal_sum;
  logic [20:0] obs;

  int tests = 0;
  int fails = 0;
  int n_acc, first_cyc, done_cyc, done_pulses;
  int exp_sugar, exp_sig;
  logic [20:0] exp_q[$];

  bit         sugar_mem [0:159][0:119];
  logic [3:0] sig_mem   [0:159][0:119];
  logic [7:0] env_x = 8'd0;
  logic [6:0] env_y = 7'd0;
  bit         addr_bad = 1'b0;

  always #5 Clk = ~Clk;

  env_scan_reader dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .lookup_X      (lookup_X),
    .lookup_Y      (lookup_Y),
    .lookup_sugar  (lookup_sugar),
    .lookup_signal (lookup_signal),
    .cell_valid    (cell_valid),
    .cell_ready    (cell_ready),
    .cell_x        (cell_x),
    .cell_y        (cell_y),
    .cell_sugar    (cell_sugar),
    .cell_signal   (cell_signal),
    .cell_last     (cell_last),
    .sugar_count   (sugar_count),
    .signal_sum    (signal_sum)
  );

  assign obs = {cell_last, cell_x, cell_y, cell_sugar, cell_signal};

  // Environment memory: data for the address seen at an edge appears during the next cycle
  always @(posedge Clk) begin
    env_x <= lookup_X;
    env_y <= lookup_Y;
    if (lookup_X > 8'd159 || lookup_Y > 7'd119) addr_bad <= 1'b1;
  end
  assign lookup_sugar  = (env_x <= 8'd159 && env_y <= 7'd119) ? sugar_mem[env_x][env_y] : 1'b0;
  assign lookup_signal = (env_x <= 8'd159 && env_y <= 7'd119) ? sig_mem[env_x][env_y]   : 4'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // mode 0: signal = x mod 16, sparse random sugar; mode 1: signal 15, sugar at 7 random cells
  task automatic setup_env(input int mode);
    int placed, px, py;
    for (int x = 0; x < 160; x++)
      for (int y = 0; y < 120; y++) begin
        sig_mem[x][y]   = (mode == 0) ? 4'(x % 16) : 4'd15;
        sugar_mem[x][y] = (mode == 0) ? ($urandom_range(7) == 0) : 1'b0;
      end
    placed = 0;
    while (mode == 1 && placed < 7) begin
      px = $urandom_range(159);
      py = $urandom_range(119);
      if (!sugar_mem[px][py]) begin
        sugar_mem[px][py] = 1'b1;
        placed++;
      end
    end
  endtask

  task automatic build_expected();
    exp_q.delete();
    exp_sugar = 0;
    exp_sig   = 0;
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++) begin
        exp_q.push_back({(x == 159 && y == 119), 8'(x), 7'(y), sugar_mem[x][y], sig_mem[x][y]});
        exp_sugar += int'(sugar_mem[x][y]);
        exp_sig   += int'(sig_mem[x][y]);
      end
  endtask

  // rmode 0: ready=1; 1: ready pattern 1,0,0,1; 2: ready=0 for 50 cycles then random
  task automatic run_scan(input int rmode, input int rst_x, input int rst_y, input bit do_restart);
    int cyc;
    bit stalled, restarted, r;
    logic [20:0] held, exp_t;
    n_acc = 0; first_cyc = -1; done_cyc = -1; done_pulses = 0;
    stalled = 1'b0; restarted = 1'b0; held = 21'd0;
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    cyc = 0;
    while (cyc < BUDGET) begin
      if (stalled) begin
        check("stall_valid", cell_valid, 1'b1);
        check("stall_hold", obs, held);
      end
      if (cyc == 0) check("busy_after_start", busy, 1'b1);
      if (cell_valid && first_cyc < 0) first_cyc = cyc;
      if (done) begin
        done_pulses++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 2) begin
        check("busy_after_done", busy, 1'b0);
        check("valid_after_done", cell_valid, 1'b0);
        break;
      end
      if (rmode == 2 && cyc == 50) begin
        check("frozen_lookup_x", lookup_X, 8'd1);
        check("frozen_lookup_y", lookup_Y, 7'd0);
        check("frozen_valid", cell_valid, 1'b1);
      end
      if (rst_x >= 0 && cell_valid && int'(cell_x) == rst_x && int'(cell_y) == rst_y) begin
        Reset_n = 1'b0;
        #1;
        check("rst_valid", cell_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(posedge Clk); #1;
        check("rst_valid_next", cell_valid, 1'b0);
        check("rst_busy_next", busy, 1'b0);
        check("rst_done_next", done, 1'b0);
        Reset_n = 1'b1;
        cell_ready = 1'b0;
        return;
      end
      start = do_restart && !restarted && cell_valid && cell_x == 8'd10 && cell_y == 7'd3;
      if (start) restarted = 1'b1;
      case (rmode)
        0: r = 1'b1;
        1: r = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: r = (cyc > 50) ? ($urandom_range(3) != 0) : 1'b0;
      endcase
      cell_ready = r;
      if (cell_valid && cell_ready) begin
        check("tuple_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          exp_t = exp_q.pop_front();
          check("tuple", obs, exp_t);
        end
        n_acc++;
      end
      stalled = cell_valid && !cell_ready;
      held = obs;
      @(posedge Clk); #1;
      cyc++;
    end
    check("scan_in_budget", cyc < BUDGET, 1'b1);
    start = 1'b0;
    cell_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge Clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_valid", cell_valid, 1'b0);
    check("rst_last", cell_last, 1'b0);
    check("rst_lookup_x", lookup_X, 8'd0);
    check("rst_lookup_y", lookup_Y, 7'd0);
    check("rst_sugar_count", sugar_count, 16'd0);
    check("rst_signal_sum", signal_sum, 24'd0);
    Reset_n = 1'b1;
    @(posedge Clk); #1;

    // Full scan at full rate, with an ignored start pulse at (10,3)
    setup_env(0);
    build_expected();
    run_scan(0, -1, -1, 1'b1);
    check("t1_count", n_acc, NCELLS);
    check("t1_leftover", exp_q.size(), 0);
    check("t1_first_valid", first_cyc, 2);
    check("t1_done_cycle", done_cyc, NCELLS + 3);
    check("t1_done_pulses", done_pulses, 1);
    check("t1_sugar_count", sugar_count, STATS ? ((exp_sugar > 65535) ? 65535 : exp_sugar) : 0);
    check("t1_signal_sum", signal_sum, STATS ? exp_sig : 0);

    // Backpressure 1,0,0,1 with the stats environment
    setup_env(1);
    build_expected();
    run_scan(1, -1, -1, 1'b0);
    check("t2_count", n_acc, NCELLS);
    check("t2_leftover", exp_q.size(), 0);
    check("t2_first_valid", first_cyc, 2);
    check("t2_done_pulses", done_pulses, 1);
    check("t2_sugar_count", sugar_count, STATS ? exp_sugar : 0);
    check("t2_signal_sum", signal_sum, STATS ? exp_sig : 0);

    // Long initial stall, random release, reset at (80,60)
    setup_env(0);
    build_expected();
    run_scan(2, 80, 60, 1'b0);
    check("t3_count_before_reset", n_acc, 60 * 160 + 80);
    @(posedge Clk); #1;

    // Scan after reset restarts at (0,0); stop it at (5,0)
    build_expected();
    run_scan(0, 5, 0, 1'b0);
    check("t5_count_before_reset", n_acc, 5);
    check("addr_in_range", addr_bad, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
